// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Initiator side of the data-memory interface. Accepts one LDR/STR
//            request at a time, computes ARM effective/writeback addresses
//            (P/U/W), sequences a word-indexed memory with registered read
//            data, and returns load data, writeback address and fault status.
// Options  : LSU_BYTE_ACCESS_EN - when defined, LDRB/STRB are supported
//            (read-merge-write for STRB). When undefined, byte requests are
//            answered with a fault and never touch memory.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_byte,
  input  logic              req_pre,
  input  logic              req_up,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [31:0]       req_store_data,
  output logic              resp_valid,
  output logic [31:0]       resp_load_data,
  output logic              resp_wb_valid,
  output logic [ADDR_W-1:0] resp_wb_addr,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read_not_write,
  output logic              mem_enable,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_BYTE_ACCESS_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_CAPTURE, ST_MERGE, ST_WRITE, ST_RESP
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_CAPTURE, ST_WRITE, ST_RESP
  } state_e;
`endif

  localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

  state_e              state_q, state_d;
  logic                load_q, load_d;
  logic                fault_q, fault_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [ADDR_W-3:0]   idx_q, idx_d;
  logic [31:0]         word_q, word_d;
`ifdef LSU_BYTE_ACCESS_EN
  logic                byte_q, byte_d;
  logic [1:0]          lane_q, lane_d;
  logic [7:0]          sbyte_q, sbyte_d;
`endif

  logic                req_ready_d, resp_valid_d, resp_wb_valid_d, resp_fault_d;
  logic [31:0]         resp_load_data_d, mem_wdata_d;
  logic [ADDR_W-1:0]   resp_wb_addr_d, mem_addr_d;
  logic                mem_read_not_write_d, mem_enable_d;

  logic [ADDR_W-1:0]   upd_addr, eff_addr;
  logic [ADDR_W-3:0]   word_idx;
  logic                acc_fault;

  // Address arithmetic and access legality for the request on the inputs.
  always_comb begin
    upd_addr  = req_up ? (req_base + req_offset) : (req_base - req_offset);
    eff_addr  = req_pre ? upd_addr : req_base;
    word_idx  = eff_addr[ADDR_W-1:2];
`ifdef LSU_BYTE_ACCESS_EN
    acc_fault = ({2'b00, word_idx} >= MEM_WORDS_A) ||
                (!req_byte && (eff_addr[1:0] != 2'b00));
`else
    acc_fault = ({2'b00, word_idx} >= MEM_WORDS_A) || req_byte ||
                (eff_addr[1:0] != 2'b00);
`endif
  end

  // Next-state, request latching, data path and registered-output values.
  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    fault_d    = fault_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    idx_d      = idx_q;
    word_d     = word_q;
`ifdef LSU_BYTE_ACCESS_EN
    byte_d     = byte_q;
    lane_d     = lane_q;
    sbyte_d    = sbyte_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load_d     = req_load;
          fault_d    = acc_fault;
          wb_valid_d = !req_pre | req_wb;
          wb_addr_d  = upd_addr;
          idx_d      = word_idx;
          word_d     = req_store_data;
`ifdef LSU_BYTE_ACCESS_EN
          byte_d     = req_byte;
          lane_d     = eff_addr[1:0];
          sbyte_d    = req_store_data[7:0];
`endif
          if (acc_fault)                  state_d = ST_RESP;
          else if (req_load || req_byte)  state_d = ST_READ;
          else                            state_d = ST_WRITE;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        word_d  = mem_rdata;
        state_d = ST_RESP;
`ifdef LSU_BYTE_ACCESS_EN
        if (byte_q) begin
          if (load_q) word_d = {24'h0, mem_rdata[{lane_q, 3'b000} +: 8]};
          else        state_d = ST_MERGE;
        end
`endif
      end
`ifdef LSU_BYTE_ACCESS_EN
      ST_MERGE: begin
        word_d[{lane_q, 3'b000} +: 8] = sbyte_q;
        state_d = ST_WRITE;
      end
`endif
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    req_ready_d          = (state_d == ST_IDLE);
    resp_valid_d         = (state_d == ST_RESP);
    resp_fault_d         = (state_d == ST_RESP) && fault_d;
    resp_wb_valid_d      = (state_d == ST_RESP) && !fault_d && wb_valid_d;
    resp_wb_addr_d       = (state_d == ST_RESP) ? wb_addr_d : '0;
    resp_load_data_d     = ((state_d == ST_RESP) && load_d && !fault_d) ? word_d : 32'h0;
    mem_enable_d         = (state_d == ST_READ);
    mem_read_not_write_d = (state_d != ST_WRITE);
    mem_addr_d           = ((state_d == ST_READ) || (state_d == ST_WRITE)) ? {2'b00, idx_d} : '0;
    mem_wdata_d          = (state_d == ST_WRITE) ? word_d : 32'h0;
  end

  // State, latched request and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      load_q             <= 1'b0;
      fault_q            <= 1'b0;
      wb_valid_q         <= 1'b0;
      wb_addr_q          <= '0;
      idx_q              <= '0;
      word_q             <= 32'h0;
`ifdef LSU_BYTE_ACCESS_EN
      byte_q             <= 1'b0;
      lane_q             <= 2'b00;
      sbyte_q            <= 8'h00;
`endif
      req_ready          <= 1'b1;
      resp_valid         <= 1'b0;
      resp_load_data     <= 32'h0;
      resp_wb_valid      <= 1'b0;
      resp_wb_addr       <= '0;
      resp_fault         <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= 32'h0;
      mem_read_not_write <= 1'b1;
      mem_enable         <= 1'b0;
    end else begin
      state_q            <= state_d;
      load_q             <= load_d;
      fault_q            <= fault_d;
      wb_valid_q         <= wb_valid_d;
      wb_addr_q          <= wb_addr_d;
      idx_q              <= idx_d;
      word_q             <= word_d;
`ifdef LSU_BYTE_ACCESS_EN
      byte_q             <= byte_d;
      lane_q             <= lane_d;
      sbyte_q            <= sbyte_d;
`endif
      req_ready          <= req_ready_d;
      resp_valid         <= resp_valid_d;
      resp_load_data     <= resp_load_data_d;
      resp_wb_valid      <= resp_wb_valid_d;
      resp_wb_addr       <= resp_wb_addr_d;
      resp_fault         <= resp_fault_d;
      mem_addr           <= mem_addr_d;
      mem_wdata          <= mem_wdata_d;
      mem_read_not_write <= mem_read_not_write_d;
      mem_enable         <= mem_enable_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit: a word memory with
//            registered read data, a transaction-level reference model and
//            directed plus randomized LDR/STR/LDRB/STRB scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int WORDS = 1024;
`ifdef LSU_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_load = 1'b0, req_byte = 1'b0;
  logic        req_pre = 1'b0, req_up = 1'b0, req_wb = 1'b0;
  logic [31:0] req_base = '0, req_offset = '0, req_store_data = '0;
  logic        req_ready, resp_valid, resp_wb_valid, resp_fault;
  logic [31:0] resp_load_data, resp_wb_addr, mem_addr, mem_wdata;
  logic        mem_read_not_write, mem_enable;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] tb_mem   [WORDS];
  logic [31:0] seed_mem [WORDS];
  logic [31:0] ref_mem  [WORDS];
  logic        mem_init = 1'b1;

  typedef struct {
    int          lat;
    logic        fault;
    logic        wbv;
    logic [31:0] wba;
    logic [31:0] ld;
    int          nen;
    logic [31:0] raddr;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          wcyc;
    logic        one_shot;
  } res_t;

  load_store_unit #(.MEM_WORDS(WORDS), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_byte(req_byte), .req_pre(req_pre), .req_up(req_up), .req_wb(req_wb),
    .req_base(req_base), .req_offset(req_offset), .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_load_data(resp_load_data),
    .resp_wb_valid(resp_wb_valid), .resp_wb_addr(resp_wb_addr), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_not_write(mem_read_not_write),
    .mem_enable(mem_enable), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: write whenever read-not-write is low, registered read data.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < WORDS; k++) tb_mem[k] <= seed_mem[k];
    end else begin
      if (mem_read_not_write === 1'b0 && mem_addr < WORDS) tb_mem[mem_addr[9:0]] <= mem_wdata;
      if (mem_enable === 1'b1 && mem_addr < WORDS) mem_rdata <= tb_mem[mem_addr[9:0]];
    end
  end

  // Transaction-level reference: outcome of one request, applied to ref_mem.
  task automatic model(input logic ld, by, p, u, w, input logic [31:0] b, o, sd,
                       output res_t e);
    logic [31:0] upd, eff, idx, word;
    int sh;
    upd = u ? b + o : b - o;
    eff = p ? upd : b;
    idx = eff / 4;
    sh  = 8 * int'(eff % 4);
    e.fault = (idx >= WORDS) || (!by && (eff % 4) != 0) || (by && !BYTE_EN);
    e.wbv = !e.fault && (!p || w);
    e.wba = upd;
    e.ld = 0; e.nen = 0; e.raddr = 0; e.nwr = 0; e.waddr = 0; e.wdata = 0; e.wcyc = 0;
    e.one_shot = 1'b1;
    if (e.fault) begin
      e.lat = 1;
    end else if (ld) begin
      e.lat = 3; e.nen = 1; e.raddr = idx;
      word = ref_mem[idx];
      e.ld = by ? ((word >> sh) & 32'hFF) : word;
    end else if (!by) begin
      e.lat = 2; e.nwr = 1; e.waddr = idx; e.wdata = sd; e.wcyc = 1;
      ref_mem[idx] = sd;
    end else begin
      e.lat = 5; e.nen = 1; e.raddr = idx; e.nwr = 1; e.waddr = idx; e.wcyc = 4;
      word = ref_mem[idx];
      e.wdata = (word & ~(32'hFF << sh)) | ({24'h0, sd[7:0]} << sh);
      ref_mem[idx] = e.wdata;
    end
  endtask

  // Present one request and record what the DUT does until its response.
  task automatic drive(input logic ld, by, p, u, w, input logic [31:0] b, o, sd,
                       output res_t r);
    int guard;
    r.lat = -1; r.fault = 0; r.wbv = 0; r.wba = 0; r.ld = 0; r.nen = 0; r.raddr = 0;
    r.nwr = 0; r.waddr = 0; r.wdata = 0; r.wcyc = 0; r.one_shot = 0;
    @(negedge clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    req_load = ld; req_byte = by; req_pre = p; req_up = u; req_wb = w;
    req_base = b; req_offset = o; req_store_data = sd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_base = $urandom; req_offset = $urandom; req_store_data = $urandom;
    req_load = $urandom_range(0, 1); req_byte = $urandom_range(0, 1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_enable === 1'b1) begin r.nen++; r.raddr = mem_addr; end
      if (mem_read_not_write !== 1'b1) begin
        r.nwr++; r.waddr = mem_addr; r.wdata = mem_wdata; r.wcyc = c;
      end
      if (resp_valid === 1'b1) begin
        r.lat = c; r.fault = resp_fault; r.wbv = resp_wb_valid;
        r.wba = resp_wb_addr; r.ld = resp_load_data;
        break;
      end
    end
    if (r.lat > 0) begin
      @(negedge clk);
      r.one_shot = (resp_valid === 1'b0) && (req_ready === 1'b1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (mem_read_not_write !== 1'b1) begin n_bad++; $display("FAIL reset mem_rnw: got %b want 1", mem_read_not_write); end
    n_vec++; if (mem_enable !== 1'b0) begin n_bad++; $display("FAIL reset mem_enable: got %b want 0", mem_enable); end
    n_vec++;
    if ({resp_load_data, resp_wb_addr, mem_addr, mem_wdata, resp_wb_valid, resp_fault} !== '0) begin
      n_bad++;
      $display("FAIL reset data outputs: got ld=%h wba=%h ma=%h wd=%h wbv=%b f=%b want all 0",
               resp_load_data, resp_wb_addr, mem_addr, mem_wdata, resp_wb_valid, resp_fault);
    end
    mem_init = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_str_ldr;
    res_t e, o;
    model(0, 0, 1, 1, 0, 32'h10, 32'h4, 32'hDEADBEEF, e);
    drive(0, 0, 1, 1, 0, 32'h10, 32'h4, 32'hDEADBEEF, o);
    n_vec++; if (o.lat !== e.lat) begin n_bad++; $display("FAIL str latency: got %0d want %0d", o.lat, e.lat); end
    n_vec++; if (o.nwr !== 1 || o.waddr !== 32'd5 || o.wdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL str write: got n=%0d a=%h d=%h want n=1 a=5 d=deadbeef", o.nwr, o.waddr, o.wdata); end
    n_vec++; if (o.wbv !== 1'b0 || o.fault !== 1'b0) begin n_bad++; $display("FAIL str wb/fault: got %b/%b want 0/0", o.wbv, o.fault); end
    model(1, 0, 1, 1, 0, 32'h10, 32'h4, 32'h0, e);
    drive(1, 0, 1, 1, 0, 32'h10, 32'h4, 32'h0, o);
    n_vec++; if (o.lat !== 3) begin n_bad++; $display("FAIL ldr latency: got %0d want 3", o.lat); end
    n_vec++; if (o.ld !== 32'hDEADBEEF || o.ld !== e.ld) begin n_bad++; $display("FAIL ldr data: got %h want deadbeef", o.ld); end
    n_vec++; if (o.nwr !== 0 || o.nen !== 1) begin n_bad++; $display("FAIL ldr mem activity: got wr=%0d en=%0d want 0/1", o.nwr, o.nen); end
    n_vec++; if (o.one_shot !== 1'b1) begin n_bad++; $display("FAIL ldr resp pulse: got %b want 1", o.one_shot); end
  endtask

  task automatic test_post_index;
    res_t e, o;
    model(1, 0, 0, 0, 0, 32'h20, 32'h8, 32'h0, e);
    drive(1, 0, 0, 0, 0, 32'h20, 32'h8, 32'h0, o);
    n_vec++; if (o.raddr !== 32'd8) begin n_bad++; $display("FAIL post mem_addr: got %0d want 8", o.raddr); end
    n_vec++; if (o.wbv !== 1'b1 || o.wba !== 32'h18) begin n_bad++; $display("FAIL post wb: got %b/%h want 1/00000018", o.wbv, o.wba); end
    n_vec++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL post data: got %h want %h", o.ld, e.ld); end
  endtask

  task automatic test_faults;
    res_t e, o;
    drive(1, 0, 1, 1, 0, 32'h22, 32'h0, 32'h0, o);
    n_vec++; if (o.fault !== 1'b1 || o.lat !== 1 || o.nen !== 0) begin
      n_bad++; $display("FAIL misalign: got f=%b lat=%0d en=%0d want 1/1/0", o.fault, o.lat, o.nen); end
    n_vec++; if (o.ld !== 0 || o.wbv !== 1'b0) begin n_bad++; $display("FAIL misalign fields: got ld=%h wbv=%b want 0/0", o.ld, o.wbv); end
    drive(1, 0, 1, 1, 1, 32'hF00, 32'h100, 32'h0, o);
    n_vec++; if (o.fault !== 1'b1 || o.lat !== 1) begin n_bad++; $display("FAIL idx1024: got f=%b lat=%0d want 1/1", o.fault, o.lat); end
    model(1, 0, 1, 1, 0, 32'hFFC, 32'h0, 32'h0, e);
    drive(1, 0, 1, 1, 0, 32'hFFC, 32'h0, 32'h0, o);
    n_vec++; if (o.fault !== 1'b0 || o.raddr !== 32'd1023 || o.ld !== e.ld) begin
      n_bad++; $display("FAIL idx1023: got f=%b a=%0d ld=%h want 0/1023/%h", o.fault, o.raddr, o.ld, e.ld); end
    drive(0, 0, 1, 0, 1, 32'h0, 32'h4, 32'h12345678, o);
    n_vec++; if (o.fault !== 1'b1 || o.nwr !== 0) begin n_bad++; $display("FAIL underflow: got f=%b wr=%0d want 1/0", o.fault, o.nwr); end
  endtask

  task automatic test_byte;
    res_t e, o;
    model(0, 0, 1, 1, 0, 32'h14, 32'h0, 32'h11223344, e);
    drive(0, 0, 1, 1, 0, 32'h14, 32'h0, 32'h11223344, o);
    model(0, 1, 1, 1, 0, 32'h15, 32'h0, 32'h000000AB, e);
    drive(0, 1, 1, 1, 0, 32'h15, 32'h0, 32'h000000AB, o);
    n_vec++; if (o.fault !== e.fault || o.lat !== e.lat) begin
      n_bad++; $display("FAIL strb fault/lat: got %b/%0d want %b/%0d", o.fault, o.lat, e.fault, e.lat); end
    n_vec++; if (o.nwr !== e.nwr || o.wdata !== e.wdata || o.wcyc !== e.wcyc) begin
      n_bad++; $display("FAIL strb write: got n=%0d d=%h cyc=%0d want n=%0d d=%h cyc=%0d",
                        o.nwr, o.wdata, o.wcyc, e.nwr, e.wdata, e.wcyc); end
`ifdef LSU_BYTE_ACCESS_EN
    n_vec++; if (o.wdata !== 32'h1122AB44) begin n_bad++; $display("FAIL strb merged word: got %h want 1122ab44", o.wdata); end
    model(1, 1, 1, 1, 0, 32'h17, 32'h0, 32'h0, e);
    drive(1, 1, 1, 1, 0, 32'h17, 32'h0, 32'h0, o);
    n_vec++; if (o.ld !== 32'h00000011 || o.lat !== 3) begin n_bad++; $display("FAIL ldrb: got %h lat=%0d want 00000011 lat=3", o.ld, o.lat); end
`else
    model(1, 0, 1, 1, 0, 32'h14, 32'h0, 32'h0, e);
    drive(1, 0, 1, 1, 0, 32'h14, 32'h0, 32'h0, o);
    n_vec++; if (o.ld !== 32'h11223344) begin n_bad++; $display("FAIL strb left memory: got %h want 11223344", o.ld); end
`endif
  endtask

  task automatic test_reset_midflight;
    res_t e, o;
    @(negedge clk);
    req_load = !BYTE_EN; req_byte = BYTE_EN; req_pre = 1; req_up = 1; req_wb = 0;
    req_base = 32'h40; req_offset = 32'h0; req_store_data = 32'h5A; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_enable !== 1'b0 || mem_read_not_write !== 1'b1) begin
      n_bad++; $display("FAIL midreset ctrl: got rdy=%b rv=%b en=%b rnw=%b want 1/0/0/1",
                        req_ready, resp_valid, mem_enable, mem_read_not_write); end
    n_vec++; if ({resp_load_data, resp_wb_addr, mem_addr, mem_wdata, resp_fault, resp_wb_valid} !== '0) begin
      n_bad++; $display("FAIL midreset data: got ma=%h wd=%h ld=%h want 0", mem_addr, mem_wdata, resp_load_data); end
    repeat (4) @(negedge clk);
    n_vec++; if (tb_mem[16] !== ref_mem[16]) begin n_bad++; $display("FAIL midreset memory: got %h want %h", tb_mem[16], ref_mem[16]); end
    model(1, 0, 1, 1, 0, 32'h40, 32'h0, 32'h0, e);
    drive(1, 0, 1, 1, 0, 32'h40, 32'h0, 32'h0, o);
    n_vec++; if (o.ld !== e.ld || o.lat !== 3) begin n_bad++; $display("FAIL post-reset ldr: got %h lat=%0d want %h lat=3", o.ld, o.lat, e.ld); end
  endtask

  task automatic test_random;
    res_t e, o;
    logic ld, by, p, u, w;
    logic [31:0] b, off, sd;
    for (int i = 0; i < 60; i++) begin
      ld = $urandom_range(0, 1); by = $urandom_range(0, 1);
      p = $urandom_range(0, 1); u = $urandom_range(0, 1); w = $urandom_range(0, 1);
      b = $urandom_range(0, 4400); sd = $urandom;
      off = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 64);
      if (!by && $urandom_range(0, 3) != 0) begin b = b & ~32'h3; off = off & ~32'h3; end
      model(ld, by, p, u, w, b, off, sd, e);
      drive(ld, by, p, u, w, b, off, sd, o);
      n_vec++; if (o.lat !== e.lat || o.fault !== e.fault) begin
        n_bad++; $display("FAIL rand[%0d] lat/fault: got %0d/%b want %0d/%b", i, o.lat, o.fault, e.lat, e.fault); end
      n_vec++; if (o.wbv !== e.wbv || (!e.fault && o.wba !== e.wba)) begin
        n_bad++; $display("FAIL rand[%0d] wb: got %b/%h want %b/%h", i, o.wbv, o.wba, e.wbv, e.wba); end
      n_vec++; if (o.ld !== e.ld) begin n_bad++; $display("FAIL rand[%0d] load data: got %h want %h", i, o.ld, e.ld); end
      n_vec++; if (o.nen !== e.nen || (e.nen > 0 && o.raddr !== e.raddr)) begin
        n_bad++; $display("FAIL rand[%0d] read: got n=%0d a=%h want n=%0d a=%h", i, o.nen, o.raddr, e.nen, e.raddr); end
      n_vec++; if (o.nwr !== e.nwr || (e.nwr > 0 && (o.waddr !== e.waddr || o.wdata !== e.wdata || o.wcyc !== e.wcyc))) begin
        n_bad++; $display("FAIL rand[%0d] write: got n=%0d a=%h d=%h c=%0d want n=%0d a=%h d=%h c=%0d",
                          i, o.nwr, o.waddr, o.wdata, o.wcyc, e.nwr, e.waddr, e.wdata, e.wcyc); end
      n_vec++; if (o.one_shot !== 1'b1) begin n_bad++; $display("FAIL rand[%0d] resp pulse: got %b want 1", i, o.one_shot); end
    end
  endtask

  task automatic test_memory_image;
    int diffs;
    @(negedge clk);
    diffs = 0;
    for (int k = 0; k < WORDS; k++) if (tb_mem[k] !== ref_mem[k]) diffs++;
    n_vec++; if (diffs != 0) begin n_bad++; $display("FAIL memory image: got %0d differing words want 0", diffs); end
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      seed_mem[k] = $urandom;
      ref_mem[k]  = seed_mem[k];
    end
    test_reset();
    test_str_ldr();
    test_post_index();
    test_faults();
    test_byte();
    test_reset_midflight();
    test_random();
    test_memory_image();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
